// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes and edge-detects peripheral done lines,
// latches them as pending, masks them, and presents one prioritized source
// at a time on hwint until software acknowledges through a memory-mapped write.
module irq_ctrl #(
    parameter int unsigned NSRC = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            sel,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    output logic [NSRC-1:0] hwint
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_COOL   = 2'd2
    } state_t;

    localparam logic [1:0] A_PEND = 2'd0;
    localparam logic [1:0] A_MASK = 2'd1;
    localparam logic [1:0] A_VEC  = 2'd2;
    localparam logic [1:0] A_ACK  = 2'd3;

    logic [NSRC-1:0] r_sync1;
    logic [NSRC-1:0] r_sync2;
    logic [NSRC-1:0] r_edge;
    logic [NSRC-1:0] r_rise;
    logic [1:0]      r_arm;
    logic            w_armed;

    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_req;
    logic            w_mask_wr;
    logic            w_ack_wr;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_lock;
    logic [2:0]      w_lock_nxt;
    logic [2:0]      w_grant_idx;
    logic [NSRC-1:0] r_hwint;
    logic [NSRC-1:0] w_hwint_nxt;

    logic            w_unused_wd;

    assign w_unused_wd = ^wd;
    assign w_armed     = (r_arm == 2'd3);
    assign w_req       = r_pend & r_mask;
    assign w_mask_wr   = sel & we & (addr == A_MASK);
    assign w_ack_wr    = sel & we & (addr == A_ACK);
    assign hwint       = r_hwint;

    // Synchronize src, register the edge flop and a one-cycle rise pulse.
    // Edges are ignored until the edge flop has tracked src for three clocks
    // after reset, so a level already high at reset release is not an event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_edge  <= '0;
            r_rise  <= '0;
            r_arm   <= '0;
        end else begin
            r_sync1 <= src;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
            r_rise  <= w_armed ? (r_sync2 & ~r_edge) : '0;
            if (!w_armed) begin
                r_arm <= r_arm + 2'd1;
            end
        end
    end

    // Pending and mask registers; a new rise wins over a same-cycle ACK clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
            r_mask <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_mask_wr) begin
                r_mask <= wd[NSRC-1:0];
            end
        end
    end

    assign w_pend_nxt = (r_pend & ~w_clr) | r_rise;

    // Lowest set index of the masked pending vector wins.
    always_comb begin
        w_grant_idx = '0;
        for (int unsigned i = NSRC; i > 0; i--) begin
            if (w_req[i-1]) begin
                w_grant_idx = 3'(i - 1);
            end
        end
    end

    // FSM state, frozen lock index and registered hwint flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_lock  <= '0;
            r_hwint <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lock  <= w_lock_nxt;
            r_hwint <= w_hwint_nxt;
        end
    end

    // Next state; hwint is decoded from the next state so it rises on the
    // same edge that enters ACTIVE.
    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock;
        w_clr       = '0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_state_nxt = ST_ACTIVE;
                    w_lock_nxt  = w_grant_idx;
                end
            end
            ST_ACTIVE: begin
                if (w_ack_wr) begin
                    w_clr       = NSRC'(1) << r_lock;
                    w_state_nxt = ST_COOL;
                end
            end
            ST_COOL: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_hwint_nxt = (w_state_nxt == ST_ACTIVE) ? (NSRC'(1) << w_lock_nxt) : '0;
    end

    // Combinational read mux.
    always_comb begin
        rd = '0;
        if (sel) begin
            case (addr)
                A_PEND: rd[NSRC-1:0] = r_pend;
                A_MASK: rd[NSRC-1:0] = r_mask;
                A_VEC: begin
                    rd[31]  = (r_state == ST_ACTIVE);
                    rd[9:8] = r_state;
                    rd[2:0] = r_lock;
                end
                default: rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: randomized traffic checked every cycle against a
// behavioural model, followed by directed scenarios with literal expectations.
module tb_irq_ctrl;

    localparam int unsigned NSRC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  hwint;

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b0;

    irq_ctrl #(.NSRC(NSRC)) dut (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wd    (wd),
        .rd    (rd),
        .hwint (hwint)
    );

    always #5 clk = ~clk;

    // Behavioural model: src samples since reset; a 0->1 step between two
    // consecutive post-reset samples becomes pending three edges later.
    logic [3:0] hist[$];
    logic [3:0] m_pend = '0;
    logic [3:0] m_mask = '0;
    logic [3:0] m_hw   = '0;
    int         m_st   = 0;   // 0 idle, 1 active, 2 cool
    int         m_lock = 0;
    logic [3:0] m_ev, m_req, m_clr;
    int         m_n;

    function automatic int lowest(logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [31:0] model_rd();
        logic [31:0] r;
        r = '0;
        if (sel) begin
            case (addr)
                2'd0: r[3:0] = m_pend;
                2'd1: r[3:0] = m_mask;
                2'd2: begin
                    r[31]  = (m_st == 1);
                    r[9:8] = 2'(m_st);
                    r[2:0] = 3'(m_lock);
                end
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist.delete();
            m_pend = '0;
            m_mask = '0;
            m_hw   = '0;
            m_st   = 0;
            m_lock = 0;
        end else begin
            m_n  = hist.size();
            m_ev = (m_n >= 4) ? (hist[m_n-3] & ~hist[m_n-4]) : 4'b0;
            hist.push_back(src);
            m_clr = '0;
            m_req = m_pend & m_mask;
            if (m_st == 0) begin
                if (m_req != 0) begin
                    m_lock = lowest(m_req);
                    m_st   = 1;
                end
            end else if (m_st == 1) begin
                if (sel && we && addr == 2'd3) begin
                    m_clr = 4'(1 << m_lock);
                    m_st  = 2;
                end
            end else begin
                m_st = 0;
            end
            if (sel && we && addr == 2'd1) m_mask = wd[3:0];
            m_pend = (m_pend & ~m_clr) | m_ev;
            m_hw   = (m_st == 1) ? 4'(1 << m_lock) : 4'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run_cmp) begin
            check("hwint", {28'b0, hwint}, {28'b0, m_hw});
            check("rd", rd, model_rd());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wd = d;
        tick();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [1:0] a, input logic [31:0] exp);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        check(name, rd, exp);
        sel = 1'b0;
    endtask

    initial begin
        reset = 1'b0; src = '0; sel = 1'b0; we = 1'b0; addr = '0; wd = '0;
        tick();
        // Reset state
        check("rst_hwint", {28'b0, hwint}, 32'h0);
        rdchk("rst_pend", 2'd0, 32'h0);
        rdchk("rst_mask", 2'd1, 32'h0);
        rdchk("rst_vec", 2'd2, 32'h0);
        run_cmp = 1'b1;
        reset = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset = ($urandom_range(399) != 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(7) == 0) src[b] = ~src[b];
            end
            sel  = 1'($urandom_range(1));
            we   = 1'($urandom_range(1));
            addr = 2'($urandom_range(3));
            wd   = $urandom;
        end

        // Clean start for directed scenarios
        sel = 1'b0; we = 1'b0; src = '0; reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        repeat (5) tick();
        wr(2'd1, 32'hF);

        // Single pulse on src[2]: pending at N+3, grant at N+4
        src = 4'b0100; tick();
        src = 4'b0000; tick(); tick();
        rdchk("pend_n2", 2'd0, 32'h0);
        tick();
        rdchk("pend_n3", 2'd0, 32'h4);
        check("hw_n3", {28'b0, hwint}, 32'h0);
        tick();
        check("hw_n4", {28'b0, hwint}, 32'h4);
        rdchk("vec_act", 2'd2, 32'h8000_0102);
        wr(2'd3, 32'h0);
        check("hw_ack", {28'b0, hwint}, 32'h0);
        rdchk("vec_cool", 2'd2, 32'h0000_0202);
        tick(); tick();
        rdchk("pend_clr", 2'd0, 32'h0);

        // src[3] and src[1] together: lowest index first
        src = 4'b1010;
        repeat (5) tick();
        check("hw_pri1", {28'b0, hwint}, 32'h2);
        wr(2'd3, 32'h0);
        check("hw_gap0", {28'b0, hwint}, 32'h0);
        tick();
        check("hw_gap1", {28'b0, hwint}, 32'h0);
        tick();
        check("hw_pri3", {28'b0, hwint}, 32'h8);
        wr(2'd3, 32'h0);
        rdchk("pend_empty", 2'd0, 32'h0);
        tick(); tick();
        check("hw_quiet", {28'b0, hwint}, 32'h0);

        // Masked pending, then unmask
        wr(2'd1, 32'h0);
        src = 4'b1011;
        repeat (5) tick();
        rdchk("pend_masked", 2'd0, 32'h1);
        check("hw_masked", {28'b0, hwint}, 32'h0);
        wr(2'd1, 32'h1);
        check("hw_unmask0", {28'b0, hwint}, 32'h0);
        tick();
        check("hw_unmask1", {28'b0, hwint}, 32'h1);
        wr(2'd3, 32'h0);
        src = 4'b0000;
        tick(); tick();

        // New src[2] edge in the same cycle as ACK of lock 2
        wr(2'd1, 32'hF);
        src = 4'b0100; tick();
        src = 4'b0000; tick();
        src = 4'b0100; tick();
        src = 4'b0000; tick();
        tick();
        check("hw_re0", {28'b0, hwint}, 32'h4);
        sel = 1'b1; we = 1'b1; addr = 2'd3; wd = 32'h0;
        tick();
        sel = 1'b0; we = 1'b0;
        check("hw_re_cool", {28'b0, hwint}, 32'h0);
        rdchk("pend_re", 2'd0, 32'h4);
        rdchk("vec_re", 2'd2, 32'h0000_0202);
        tick(); tick();
        check("hw_re_again", {28'b0, hwint}, 32'h4);
        wr(2'd3, 32'h0);
        tick(); tick();

        // Ignored writes and read-only behaviour
        wr(2'd3, 32'h0);
        rdchk("vec_idle", 2'd2, 32'h0000_0002);
        wr(2'd0, 32'hF);
        rdchk("pend_ro", 2'd0, 32'h0);
        rdchk("ack_rd", 2'd3, 32'h0);
        addr = 2'd1; sel = 1'b0;
        #1;
        check("nosel_rd", rd, 32'h0);

        // Reset mid-ACTIVE with src[1] held high
        src = 4'b0010;
        repeat (5) tick();
        check("hw_pre_rst", {28'b0, hwint}, 32'h2);
        reset = 1'b0;
        #1;
        check("hw_rst", {28'b0, hwint}, 32'h0);
        rdchk("vec_rst", 2'd2, 32'h0);
        tick(); tick();
        reset = 1'b1;
        wr(2'd1, 32'hF);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("no_grant", {28'b0, hwint}, 32'h0);
        end
        src = 4'b0000;
        tick(); tick();

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
